// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready stage with registered s_ready, full throughput and flush.
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] skid;
    logic s_hs, ld_main, ld_skid, from_skid;
    assign s_hs = s_valid & s_ready;
    always_comb begin
        nxt = state;
        ld_main = 1'b0;
        ld_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            EMPTY: begin
                nxt = s_hs ? BUSY : EMPTY;
                ld_main = s_hs;
            end
            BUSY: begin
                nxt = s_hs ? (m_ready ? BUSY : FULL) : (m_ready ? EMPTY : BUSY);
                ld_main = s_hs & m_ready;
                ld_skid = s_hs & ~m_ready;
            end
            FULL: begin
                nxt = m_ready ? BUSY : FULL;
                ld_main = m_ready;
                from_skid = 1'b1;
            end
            default: nxt = EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            m_valid <= 1'b0;
            s_ready <= 1'b0;
            m_data <= '0;
            skid <= '0;
        end else if (flush) begin
            state <= EMPTY;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            state <= nxt;
            m_valid <= nxt != EMPTY;
            s_ready <= nxt != FULL;
            if (ld_main) m_data <= from_skid ? skid : s_data;
            if (ld_skid) skid <= s_data;
        end
    end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed and random checks of pipe_skid_buffer against a FIFO scoreboard.
module tb_pipe_skid_buffer;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
    logic [31:0] s_data = '0, m_data;
    int tests = 0, fails = 0, pushed = 0;
    logic [31:0] q[$];
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: the stage behaves as an in-order FIFO of at most two beats.
    always @(negedge clk) begin
        if (rst || flush) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("m_valid_vs_model", {31'd0, m_valid}, {31'd0, q.size() != 0});
            if (q.size() == 2) chk("s_ready_when_full", {31'd0, s_ready}, 32'd0);
            if (prev_stall) chk("stall_stable_data", m_data, prev_data);
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_beat: got %h want none", m_data);
                end else chk("beat_order", m_data, q.pop_front());
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                pushed++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    initial begin
        int base;
        logic hs;
        repeat (2) cyc();
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_m_data", m_data, 32'd0);
        chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("s_ready_after_reset", {31'd0, s_ready}, 32'd1);

        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data = i;
            cyc();
            chk("stream_data", m_data, i);
            chk("stream_valid", {31'd0, m_valid}, 32'd1);
            chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
        end
        s_valid = 1'b0;
        cyc();
        chk("stream_end_valid", {31'd0, m_valid}, 32'd0);

        s_valid = 1'b1;
        s_data = 32'hA;
        cyc();
        chk("stall_a", m_data, 32'hA);
        s_data = 32'hB;
        m_ready = 1'b0;
        cyc();
        chk("stall_full_s_ready", {31'd0, s_ready}, 32'd0);
        chk("stall_hold_a", m_data, 32'hA);
        s_data = 32'hC;
        repeat (2) cyc();
        chk("stall_still_full", {31'd0, s_ready}, 32'd0);
        chk("stall_still_a", m_data, 32'hA);
        m_ready = 1'b1;
        cyc();
        chk("stall_b", m_data, 32'hB);
        chk("stall_ready_again", {31'd0, s_ready}, 32'd1);
        cyc();
        chk("stall_c", m_data, 32'hC);
        s_valid = 1'b0;
        cyc();
        chk("stall_drained", {31'd0, m_valid}, 32'd0);

        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 32'hDEAD;
        cyc();
        s_valid = 1'b0;
        repeat (5) begin
            cyc();
            chk("bp_data", m_data, 32'hDEAD);
            chk("bp_valid", {31'd0, m_valid}, 32'd1);
        end
        m_ready = 1'b1;
        cyc();
        chk("bp_released", {31'd0, m_valid}, 32'd0);

        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 32'h11;
        cyc();
        s_data = 32'h22;
        cyc();
        chk("flush_pre_full", {31'd0, s_ready}, 32'd0);
        s_data = 32'h55;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        s_valid = 1'b0;
        chk("flush_m_valid", {31'd0, m_valid}, 32'd0);
        chk("flush_s_ready", {31'd0, s_ready}, 32'd1);
        m_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("flush_no_55", {31'd0, m_valid}, 32'd0);
        end

        base = pushed;
        for (int c = 0; c < 60000 && pushed - base < 10000; c++) begin
            hs = s_valid && s_ready;
            if (hs || !s_valid) begin
                s_valid = $urandom_range(0, 3) != 0;
                s_data = $urandom;
            end
            m_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        chk("random_beats", {31'd0, pushed - base >= 10000}, 32'd1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) cyc();
        chk("random_drain", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
